alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits.
REQ-002 The module SHALL have parameter OP_W, default 3, meaning the opcode width in bits.
REQ-003 The module SHALL have parameter NUM_OPS, default 6, meaning the number of legal opcodes (0..NUM_OPS-1).
REQ-004 The module SHALL have parameter LAT, default 1, meaning the ALU result latency in clk cycles after its inputs change (0..7).
REQ-005 The module SHALL have a single clock `clk` and a reset `rst`; `rst` is asynchronous and active-high.
REQ-006 The module SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_a, req_b  in  WIDTH  operands.
- req_op  in  OP_W  opcode.
- alu_a, alu_b  out  WIDTH  operands driven to the ALU.
- alu_op  out  OP_W  opcode driven to the ALU.
- alu_out  in  WIDTH  ALU result.
- alu_c  in  1  ALU carry.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a clk edge.
- rsp_out  out  WIDTH  captured result.
- rsp_c  out  1  captured carry.
- rsp_err  out  1  illegal opcode flag.
- busy  out  1  high whenever the state is not IDLE.
- txn_cnt  out  16  completed-response counter.

Function
REQ-007 The module SHALL use three states: IDLE, WAIT, RESP.
REQ-008 req_ready SHALL be 1 in IDLE, 1 in RESP when rsp_ready is 1, and 0 otherwise, computed combinationally.
REQ-009 On acceptance of a legal opcode (req_op < NUM_OPS), the module SHALL register req_a, req_b and req_op onto alu_a, alu_b and alu_op at that same edge, and go to WAIT with wait counter = LAT.
REQ-010 In WAIT the counter SHALL decrement each cycle; at the edge where the counter is 0, the module SHALL capture alu_out and alu_c into rsp_out and rsp_c, set rsp_err=0, and go to RESP.
REQ-011 Latency from the accept edge to the rsp_valid rising edge SHALL be exactly LAT+1 cycles.
REQ-012 With LAT=0, the capture SHALL occur one edge after acceptance.
REQ-013 On acceptance of an illegal opcode, alu_a, alu_b and alu_op SHALL be unchanged, and the module SHALL go to RESP at the next edge with rsp_out=0, rsp_c=0 and rsp_err=1.
REQ-014 In RESP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be held stable until the handshake.
REQ-015 On the RESP handshake without a new request, the module SHALL return to IDLE and rsp_valid SHALL fall at that edge.
REQ-016 On the RESP handshake with req_valid=1 (back-to-back), the module SHALL process the new request per REQ-009 or REQ-013 at the same edge, with no IDLE bubble.
REQ-017 alu_a, alu_b and alu_op SHALL hold their last issued values in IDLE, WAIT and RESP.
REQ-018 txn_cnt SHALL increment by 1 on every response handshake, including rsp_err responses, and SHALL wrap from 0xFFFF to 0x0000.
REQ-019 Requests presented while req_ready=0 SHALL be ignored; the module SHALL never drop or duplicate an accepted request.

Reset
REQ-020 While rst=1, the module SHALL force state=IDLE and set alu_a, alu_b, alu_op, rsp_out, rsp_c, rsp_err, rsp_valid, busy and txn_cnt to 0, independent of clk.
REQ-021 A reset asserted mid-WAIT or mid-RESP SHALL abandon the transaction with no response and no txn_cnt increment.
REQ-022 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-023 The bench SHALL cover these directed scenarios, run with WIDTH=8, LAT=1 and a bench ALU stub that returns out=a+b (low 8 bits) with c as the carry:
- Basic add: req a=0x05, b=0x03, op=0 -> rsp_valid 2 cycles after accept; rsp_out=0x08, rsp_c=0, rsp_err=0; txn_cnt=1 after handshake.
- Carry: a=0xFF, b=0x01, op=0 -> rsp_out=0x00, rsp_c=1.
- Illegal op: op=7 -> rsp_valid 1 cycle after accept; rsp_err=1, rsp_out=0; alu_* unchanged.
- Backpressure then back-to-back: rsp_ready held 0 for 5 cycles -> rsp_* stable; then rsp_ready=1 with a new req_valid -> new request accepted on the same edge, second response correct.
- Reset mid-WAIT: assert rst one cycle after accept -> all outputs 0 immediately, no response, txn_cnt=0.
- Counter wrap: preload by issuing 65536 responses -> txn_cnt reads 0x0000.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer around a fixed-latency ALU: issues operands,
// waits LAT cycles, captures the result and holds it until consumed.
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int OP_W    = 3,
  parameter int NUM_OPS = 6,
  parameter int LAT     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_c,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      txn_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic [2:0] wait_cnt;
  logic       err_pend;
  logic       accept;
  logic       legal;

  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign legal     = 32'(req_op) < NUM_OPS;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // An illegal opcode still passes through WAIT with a zero count, so its
  // error response appears one edge after acceptance.
  // NOTE: every register here is plain control/data state, so all of it sits
  // under the async reset; non-blocking assignments keep the edge semantics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_pend <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_out  <= '0;
      rsp_c    <= 1'b0;
      rsp_err  <= 1'b0;
      txn_cnt  <= '0;
    end else begin
      if (rsp_valid && rsp_ready) txn_cnt <= txn_cnt + 16'd1;

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (legal) begin
              alu_a    <= req_a;
              alu_b    <= req_b;
              alu_op   <= req_op;
              wait_cnt <= 3'(LAT);
              err_pend <= 1'b0;
            end else begin
              wait_cnt <= '0;
              err_pend <= 1'b1;
            end
            state <= WAIT;
          end else if (state == RESP && rsp_ready) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_out <= err_pend ? '0 : alu_out;
            rsp_c   <= err_pend ? 1'b0 : alu_c;
            rsp_err <= err_pend;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an a+b ALU stub (WIDTH=8, LAT=1).
module tb_alu_op_sequencer;

  logic       clk, rst;
  logic       req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic [2:0] req_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic       alu_c;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_out;
  logic       rsp_c, rsp_err, busy;
  logic [15:0] txn_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [7:0] last_a = '0, last_b = '0;
  logic [2:0] last_op = '0;

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] out;
    logic       c, err;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  alu_op_sequencer #(.WIDTH(8), .OP_W(3), .NUM_OPS(6), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  assign {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts edges from the accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_a = v.a; req_b = v.b; req_op = v.op; rsp_ready = 1'b0;
    #1 check({tag, " req_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " rsp_out"}, rsp_out, v.out);
    check({tag, " rsp_c"}, rsp_c, v.c);
    check({tag, " rsp_err"}, rsp_err, v.err);
    if (!v.err) begin last_a = v.a; last_b = v.b; last_op = v.op; end
    check({tag, " alu_a"}, alu_a, last_a);
    check({tag, " alu_b"}, alu_b, last_b);
    check({tag, " alu_op"}, alu_op, last_op);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    check({tag, " txn_cnt"}, txn_cnt, exp_cnt);
    check({tag, " rsp_valid fell"}, rsp_valid, 0);
    check({tag, " idle"}, busy, 0);
  endtask

  initial begin
    int lat, hs, cyc;
    logic seen;

    vecs[0] = '{a: 8'h05, b: 8'h03, op: 3'd0, out: 8'h08, c: 1'b0, err: 1'b0, lat: 2};
    vecs[1] = '{a: 8'hFF, b: 8'h01, op: 3'd0, out: 8'h00, c: 1'b1, err: 1'b0, lat: 2};
    vecs[2] = '{a: 8'h12, b: 8'h34, op: 3'd7, out: 8'h00, c: 1'b0, err: 1'b1, lat: 1};
    vecs[3] = '{a: 8'h80, b: 8'h80, op: 3'd5, out: 8'h00, c: 1'b1, err: 1'b0, lat: 2};
    vecs[4] = '{a: 8'h7F, b: 8'h01, op: 3'd6, out: 8'h00, c: 1'b0, err: 1'b1, lat: 1};
    vecs[5] = '{a: 8'h7F, b: 8'h01, op: 3'd3, out: 8'h80, c: 1'b0, err: 1'b0, lat: 2};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset busy", busy, 0);
    check("reset txn_cnt", txn_cnt, 0);
    check("reset alu_a", alu_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post-reset req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with an ignored request, then a back-to-back accept.
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h10; req_b = 8'h20; req_op = 3'd1; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("bp latency", lat, 2);
    req_valid = 1'b1; req_a = 8'hAA; req_b = 8'h11; req_op = 3'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d rsp_out", k), rsp_out, 8'h30);
      check($sformatf("bp hold%0d rsp_valid", k), rsp_valid, 1);
      check($sformatf("bp hold%0d req_ready", k), req_ready, 0);
    end
    check("bp ignored alu_a", alu_a, 8'h10);
    rsp_ready = 1'b1;
    #1 check("b2b req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    exp_cnt++;
    check("b2b txn_cnt", txn_cnt, exp_cnt);
    check("b2b no bubble busy", busy, 1);
    check("b2b alu_a", alu_a, 8'hAA);
    wait_rsp(lat);
    check("b2b latency", lat, 2);
    check("b2b rsp_out", rsp_out, 8'hBB);
    check("b2b rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    check("b2b final txn_cnt", txn_cnt, exp_cnt);

    // Reset one cycle after accept abandons the transaction.
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h01; req_b = 8'h02; req_op = 3'd0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midwait rst busy", busy, 0);
    check("midwait rst alu_a", alu_a, 0);
    check("midwait rst rsp_out", rsp_out, 0);
    check("midwait rst txn_cnt", txn_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midwait req_ready", req_ready, 1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("midwait no response", seen, 0);
    check("midwait txn_cnt", txn_cnt, 0);

    // 65536 back-to-back error responses wrap the counter.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; rsp_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 65536 && cyc < 140000) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        hs++;
        if (hs == 65536) begin
          check("wrap pre txn_cnt", txn_cnt, 16'hFFFF);
          req_valid = 1'b0;
        end
      end
    end
    check("wrap handshakes", hs, 65536);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("wrap txn_cnt", txn_cnt, 16'h0000);
    check("wrap idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
